// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two requesters share one multi-cycle ALU and returns the captured result.
// Optional macro ALU_ARB_ILLEGAL_OP_EN: codes 1100-1111 are trapped (rsp_err=1, rsp_data=0) instead of reaching the ALU.
module alu_arbiter #(
    parameter int REG_SIZE      = 32,
    parameter int SIMPLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [3:0]              req0_op,
    input  logic [REG_SIZE-1:0]     req0_a,
    input  logic [REG_SIZE-1:0]     req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [3:0]              req1_op,
    input  logic [REG_SIZE-1:0]     req1_a,
    input  logic [REG_SIZE-1:0]     req1_b,
    output logic [3:0]              alu_ctrl_sig,
    output logic [REG_SIZE-1:0]     alu_a_data,
    output logic [REG_SIZE-1:0]     alu_b_data,
    input  logic [2*REG_SIZE-1:0]   alu_c_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [2*REG_SIZE-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int MAX_CYCLES = (MULDIV_CYCLES > SIMPLE_CYCLES) ? MULDIV_CYCLES : SIMPLE_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] SIMPLE_LOAD = CW'(SIMPLE_CYCLES - 1);
    localparam logic [CW-1:0] MULDIV_LOAD = CW'(MULDIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic                   r_last;
    logic                   r_trap;
    logic [3:0]             r_alu_ctrl;
    logic [REG_SIZE-1:0]    r_alu_a;
    logic [REG_SIZE-1:0]    r_alu_b;
    logic                   r_rsp_valid;
    logic                   r_rsp_id;
    logic [2*REG_SIZE-1:0]  r_rsp_data;
    logic                   r_rsp_err;

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_acc0;
    logic                   w_acc1;
    logic                   w_acc;
    logic [3:0]             w_sel_op;
    logic [REG_SIZE-1:0]    w_sel_a;
    logic [REG_SIZE-1:0]    w_sel_b;
    logic                   w_trap;
    logic [CW-1:0]          w_load;
    logic                   w_capture;
    logic                   w_release;

    // Round-robin grant: on a tie the requester not served last wins (r_last=1 means req1 went last).
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
        end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
        end
    end

    // Ready is gated by clr so nothing is offered while reset is asserted.
    assign w_acc0   = (r_state == ST_IDLE) && clr && w_gnt0;
    assign w_acc1   = (r_state == ST_IDLE) && clr && w_gnt1;
    assign w_acc    = w_acc0 || w_acc1;
    assign w_sel_op = w_acc1 ? req1_op : req0_op;
    assign w_sel_a  = w_acc1 ? req1_a  : req0_a;
    assign w_sel_b  = w_acc1 ? req1_b  : req0_b;
    assign w_load   = ((w_sel_op == 4'b1000) || (w_sel_op == 4'b1001)) ? MULDIV_LOAD : SIMPLE_LOAD;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign w_trap = (w_sel_op[3:2] == 2'b11);
`else
    assign w_trap = 1'b0;
`endif

    // Next-state decode with capture/release strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_RESP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand/response datapath; ALU inputs hold from accept until the next accept.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt       <= CNT_ZERO;
            r_last      <= 1'b1;
            r_trap      <= 1'b0;
            r_alu_ctrl  <= 4'b0000;
            r_alu_a     <= {REG_SIZE{1'b0}};
            r_alu_b     <= {REG_SIZE{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= {(2*REG_SIZE){1'b0}};
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_alu_ctrl <= w_trap ? 4'b0000 : w_sel_op;
                r_alu_a    <= w_sel_a;
                r_alu_b    <= w_sel_b;
                r_rsp_id   <= w_acc1;
                r_last     <= w_acc1;
                r_trap     <= w_trap;
                r_cnt      <= w_load;
            end else if ((r_state == ST_EXEC) && (r_cnt != CNT_ZERO)) begin
                r_cnt <= r_cnt - CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end

            if (w_capture) begin
                r_rsp_data  <= r_trap ? {(2*REG_SIZE){1'b0}} : alu_c_data;
                r_rsp_err   <= r_trap;
                r_rsp_valid <= 1'b1;
            end else if (w_release) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
        end
    end

    assign req0_ready   = w_acc0;
    assign req1_ready   = w_acc1;
    assign alu_ctrl_sig = r_alu_ctrl;
    assign alu_a_data   = r_alu_a;
    assign alu_b_data   = r_alu_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign busy         = (r_state != ST_IDLE);

endmodule
